// File: rtl/fmul32_pkg.sv
// fmul32_pkg: shared opcode/rounding enums, binary32 layout, constants and operand unpacking.
// FMUL32_SUBNORMAL_EN enables pre-normalization of subnormal operands; otherwise they flush to zero.
package fmul32_pkg;

  typedef enum logic [1:0] {
    OPC_MUL  = 2'b00,
    OPC_NMUL = 2'b01,
    OPC_AMUL = 2'b10,
    OPC_NOP  = 2'b11
  } opc_e;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  // exp is a 10-bit two's-complement biased exponent; man carries the explicit leading bit.
  typedef struct packed {
    logic        nan;
    logic        inf;
    logic        zero;
    logic [9:0]  exp;
    logic [23:0] man;
  } unpack_t;

  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] MAX_FIN = 32'h7F7F_FFFF;

`ifdef FMUL32_SUBNORMAL_EN
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) lzc24 = 5'(23 - i);
    end
  endfunction
`endif

  function automatic unpack_t unpack(input fp32_t x);
    unpack_t u;
`ifdef FMUL32_SUBNORMAL_EN
    logic [4:0] lz;
`endif
    u      = '0;
    u.nan  = (x.exp == 8'hFF) && (x.man != 23'd0);
    u.inf  = (x.exp == 8'hFF) && (x.man == 23'd0);
    if (x.exp == 8'd0) begin
`ifdef FMUL32_SUBNORMAL_EN
      if (x.man == 23'd0) begin
        u.zero = 1'b1;
      end else begin
        lz    = lzc24({1'b0, x.man});
        u.man = {1'b0, x.man} << lz;
        u.exp = 10'd1 - {5'd0, lz};
      end
`else
      u.zero = 1'b1;
`endif
    end else begin
      u.exp = {2'b00, x.exp};
      u.man = {1'b1, x.man};
    end
    return u;
  endfunction

endpackage

// File: rtl/fmul32_round.sv
// fmul32_round: combinational normalize, denormalize/flush, round and overflow saturation.
// FMUL32_SUBNORMAL_EN selects gradual underflow; otherwise tiny results flush to signed zero.
module fmul32_round
  import fmul32_pkg::*;
(
  input  logic        i_sign,
  input  logic [9:0]  i_exp,
  input  logic [47:0] i_prod,
  input  logic [1:0]  i_rmode,
  output logic [31:0] o_result
);

  rmode_e      w_rm;
  logic [47:0] w_norm;
  logic [47:0] w_den;
  logic [9:0]  w_exp;
  logic [9:0]  w_exp_rnd;
  logic [23:0] w_sig;
  logic [24:0] w_rnd;
  logic        w_g, w_r, w_s, w_inexact, w_inc, w_tiny, w_ovf, w_lost;
`ifdef FMUL32_SUBNORMAL_EN
  logic [9:0]  w_sh;
`endif

  always_comb begin
    w_rm   = rmode_e'(i_rmode);
    w_norm = i_prod[47] ? i_prod : {i_prod[46:0], 1'b0};
    w_exp  = i_prod[47] ? i_exp + 10'd1 : i_exp;
    w_tiny = $signed(w_exp) < 10'sd1;

`ifdef FMUL32_SUBNORMAL_EN
    // Shift into the subnormal range; everything shifted out joins the sticky bit.
    w_sh   = 10'd1 - w_exp;
    w_den  = w_tiny ? (w_norm >> w_sh) : w_norm;
    w_lost = w_tiny && ((w_norm & ~({48{1'b1}} << w_sh)) != 48'd0);
`else
    w_den  = w_norm;
    w_lost = 1'b0;
`endif

    w_sig     = w_den[47:24];
    w_g       = w_den[23];
    w_r       = w_den[22];
    w_s       = (|w_den[21:0]) | w_lost;
    w_inexact = w_g | w_r | w_s;

    w_inc = 1'b0;
    case (w_rm)
      RM_RNE:  w_inc = w_g & (w_r | w_s | w_sig[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RUP:  w_inc = w_inexact & ~i_sign;
      RM_RDN:  w_inc = w_inexact & i_sign;
      default: w_inc = 1'b0;
    endcase

    w_rnd = {1'b0, w_sig} + {24'd0, w_inc};
    // Leading bits are 01 normally and 10 after a rounding carry, giving +0 or +1 on the exponent.
    w_exp_rnd = w_exp - 10'd1 + {8'd0, w_rnd[24:23]};
    w_ovf     = !w_tiny && (int'($signed(w_exp_rnd)) >= EXP_MAX);

    o_result = {i_sign, w_exp_rnd[7:0], w_rnd[22:0]};
    if (w_ovf) begin
      case (w_rm)
        RM_RTZ:  o_result = {i_sign, MAX_FIN[30:0]};
        RM_RUP:  o_result = i_sign ? {1'b1, MAX_FIN[30:0]} : POS_INF;
        RM_RDN:  o_result = i_sign ? {1'b1, POS_INF[30:0]} : MAX_FIN;
        default: o_result = {i_sign, POS_INF[30:0]};
      endcase
    end else if (w_tiny) begin
`ifdef FMUL32_SUBNORMAL_EN
      // A carry into bit 23 lands the value on the minimum normal exponent.
      o_result = {i_sign, 7'd0, w_rnd[23:0]};
`else
      o_result = {i_sign, 31'd0};
`endif
    end
  end

endmodule

// File: rtl/fmul32.sv
// fmul32: binary32 multiplier; input register, product stage, round stage (result 2 edges after sampling).
// Define FMUL32_SUBNORMAL_EN for gradual underflow; the default build flushes subnormals to zero.
module fmul32
  import fmul32_pkg::*;
#(
  parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [1:0]  opc,
  input  logic [1:0]  r_mode,
  output logic [31:0] result,
  output logic        val
);

  logic        r0_vld;
  logic [31:0] r0_a, r0_b;
  logic [1:0]  r0_opc, r0_rm;

  logic        r1_vld, r1_sign, r1_nan, r1_inf, r1_zero;
  logic [1:0]  r1_opc, r1_rm;
  logic [9:0]  r1_exp;
  logic [47:0] r1_prod;

  logic [31:0] r_result;
  logic        r_val;

  unpack_t     w_ua, w_ub;
  logic [47:0] w_prod;
  logic [9:0]  w_exp_sum;
  logic        w_nan, w_inf, w_zero;
  logic        w_sign_fin;
  logic [31:0] w_rnd_res, w_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_vld <= 1'b0;
      r0_a   <= '0;
      r0_b   <= '0;
      r0_opc <= '0;
      r0_rm  <= '0;
    end else begin
      r0_vld <= (opc_e'(opc) != OPC_NOP);
      r0_a   <= op1;
      r0_b   <= op2;
      r0_opc <= opc;
      r0_rm  <= r_mode;
    end
  end

  always_comb begin
    w_ua      = unpack(fp32_t'(r0_a));
    w_ub      = unpack(fp32_t'(r0_b));
    w_exp_sum = w_ua.exp + w_ub.exp - 10'(BIAS);
    w_prod    = {24'd0, w_ua.man} * {24'd0, w_ub.man};
    w_nan     = w_ua.nan | w_ub.nan | (w_ua.inf & w_ub.zero) | (w_ua.zero & w_ub.inf);
    w_inf     = w_ua.inf | w_ub.inf;
    w_zero    = w_ua.zero | w_ub.zero;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_vld  <= 1'b0;
      r1_sign <= 1'b0;
      r1_nan  <= 1'b0;
      r1_inf  <= 1'b0;
      r1_zero <= 1'b0;
      r1_opc  <= '0;
      r1_rm   <= '0;
      r1_exp  <= '0;
      r1_prod <= '0;
    end else begin
      r1_vld  <= r0_vld;
      r1_sign <= r0_a[31] ^ r0_b[31];
      r1_nan  <= w_nan;
      r1_inf  <= w_inf;
      r1_zero <= w_zero;
      r1_opc  <= r0_opc;
      r1_rm   <= r0_rm;
      r1_exp  <= w_exp_sum;
      r1_prod <= w_prod;
    end
  end

  // The sign is fixed before rounding so directed modes see the final sign.
  always_comb begin
    w_sign_fin = r1_sign;
    case (opc_e'(r1_opc))
      OPC_NMUL: w_sign_fin = ~r1_sign;
      OPC_AMUL: w_sign_fin = 1'b0;
      default:  w_sign_fin = r1_sign;
    endcase
  end

  fmul32_round u_round (
    .i_sign   (w_sign_fin),
    .i_exp    (r1_exp),
    .i_prod   (r1_prod),
    .i_rmode  (r1_rm),
    .o_result (w_rnd_res)
  );

  always_comb begin
    w_res = w_rnd_res;
    if (r1_nan) begin
      w_res = CANON_NAN;
    end else if (r1_inf) begin
      w_res = {w_sign_fin, POS_INF[30:0]};
    end else if (r1_zero) begin
      w_res = {w_sign_fin, 31'd0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_val    <= 1'b0;
    end else begin
      r_val <= r1_vld;
      if (r1_vld) r_result <= w_res;
    end
  end

  assign result = r_result;
  assign val    = r_val;

endmodule

// File: tb/tb_fmul32.sv
// tb_fmul32: directed self-checking bench for the fmul32 binary32 multiplier.
module tb_fmul32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op1, op2;
  logic [1:0]  opc, r_mode;
  logic [31:0] result;
  logic        val;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  fmul32 dut (
    .clk    (clk),
    .rst    (rst),
    .op1    (op1),
    .op2    (op2),
    .opc    (opc),
    .r_mode (r_mode),
    .result (result),
    .val    (val)
  );

  // Issue one op, then idle; returns val one edge early (v_mid) and the result two edges after sampling.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                       input logic [1:0] rm, output logic [31:0] res, output logic v,
                       output logic v_mid);
    @(negedge clk);
    op1 = a; op2 = b; opc = o; r_mode = rm;
    @(negedge clk);
    opc = 2'b11;
    @(negedge clk);
    v_mid = val;
    @(negedge clk);
    res = result;
    v   = val;
  endtask

  task automatic test_reset;
    rst = 1'b1; op1 = 32'h3F80_0000; op2 = 32'h4000_0000; opc = 2'b00; r_mode = 2'b00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (val !== 1'b0) begin
      n_fails++; $display("FAIL reset_val: got %b expected 0", val);
    end
    n_checks++;
    if (result !== 32'h0) begin
      n_fails++; $display("FAIL reset_result: got %h expected 00000000", result);
    end
    opc = 2'b11;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] ta [2] = '{32'h3F80_0000, 32'h3FC0_0000};
    logic [31:0] te [2] = '{32'h4000_0000, 32'h4040_0000};
    logic [31:0] res;
    logic        v, vm;
    for (int i = 0; i < 2; i++) begin
      do_op(ta[i], 32'h4000_0000, 2'b00, 2'b00, res, v, vm);
      n_checks++;
      if (vm !== 1'b0) begin
        n_fails++; $display("FAIL basic[%0d] early val: got %b expected 0", i, vm);
      end
      n_checks++;
      if (v !== 1'b1) begin
        n_fails++; $display("FAIL basic[%0d] val: got %b expected 1", i, v);
      end
      n_checks++;
      if (res !== te[i]) begin
        n_fails++; $display("FAIL basic[%0d] result: got %h expected %h", i, res, te[i]);
      end
    end
  endtask

  task automatic test_sign_ops;
    logic [31:0] ta [3] = '{32'h3FC0_0000, 32'hBFC0_0000, 32'h3FC0_0000};
    logic [1:0]  to [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] te [3] = '{32'hC040_0000, 32'h4040_0000, 32'h4040_0000};
    logic        tv [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] res;
    logic        v, vm;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], 32'h4000_0000, to[i], 2'b00, res, v, vm);
      n_checks++;
      if (v !== tv[i]) begin
        n_fails++; $display("FAIL sign[%0d] val: got %b expected %b", i, v, tv[i]);
      end
      n_checks++;
      if (res !== te[i]) begin
        n_fails++; $display("FAIL sign[%0d] result: got %h expected %h", i, res, te[i]);
      end
    end
  endtask

  task automatic test_rounding;
    logic [31:0] ta [9] = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0001,
                            32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0001,
                            32'h3F80_0003};
    logic [31:0] tb [9] = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0001,
                            32'h3FC0_0000, 32'h3FC0_0000, 32'h3FC0_0000, 32'h3FC0_0000,
                            32'h3FC0_0000};
    logic [1:0]  to [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic [1:0]  tr [9] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [31:0] te [9] = '{32'h3F80_0002, 32'h3F80_0002, 32'h3F80_0003, 32'h3F80_0002,
                            32'h3FC0_0002, 32'h3FC0_0001, 32'hBFC0_0002, 32'hBFC0_0001,
                            32'h3FC0_0004};
    logic [31:0] res;
    logic        v, vm;
    for (int i = 0; i < 9; i++) begin
      do_op(ta[i], tb[i], to[i], tr[i], res, v, vm);
      n_checks++;
      if (v !== 1'b1 || res !== te[i]) begin
        n_fails++;
        $display("FAIL round[%0d]: got val=%b %h expected val=1 %h", i, v, res, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] te [4] = '{32'h3F80_0002, 32'h3F80_0002, 32'h3F80_0003, 32'hBF80_0003};
    logic [31:0] ta [4] = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0001, 32'hBF80_0001};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        n_checks++;
        if (val !== 1'b1 || result !== te[c-3]) begin
          n_fails++;
          $display("FAIL b2b[%0d]: got val=%b %h expected val=1 %h", c - 3, val, result, te[c-3]);
        end
      end
      if (c < 4) begin
        op1 = ta[c]; op2 = 32'h3F80_0001; opc = 2'b00; r_mode = 2'(c);
      end else begin
        opc = 2'b11;
      end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] ta [8] = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F7F_FFFF,
                            32'hFF7F_FFFF, 32'hFF7F_FFFF, 32'hFF7F_FFFF, 32'hFF7F_FFFF};
    logic [31:0] te [8] = '{32'h7F80_0000, 32'h7F7F_FFFF, 32'h7F80_0000, 32'h7F7F_FFFF,
                            32'hFF80_0000, 32'hFF7F_FFFF, 32'hFF7F_FFFF, 32'hFF80_0000};
    logic [31:0] res;
    logic        v, vm;
    for (int i = 0; i < 8; i++) begin
      do_op(ta[i], 32'h4000_0000, 2'b00, 2'(i % 4), res, v, vm);
      n_checks++;
      if (v !== 1'b1 || res !== te[i]) begin
        n_fails++;
        $display("FAIL ovf[%0d]: got val=%b %h expected val=1 %h", i, v, res, te[i]);
      end
    end
  endtask

  task automatic test_specials;
    logic [31:0] ta [7] = '{32'h7F80_0000, 32'h7FC0_0001, 32'hFF80_0000, 32'h8000_0000,
                            32'h7FC0_0001, 32'h0000_0000, 32'h8000_0000};
    logic [31:0] tb [7] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000,
                            32'h3F80_0000, 32'hFF80_0000, 32'h3F80_0000};
    logic [1:0]  to [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
    logic [31:0] te [7] = '{32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000,
                            32'h7FC0_0000, 32'h7FC0_0000, 32'h0000_0000};
    logic [31:0] res;
    logic        v, vm;
    for (int i = 0; i < 7; i++) begin
      do_op(ta[i], tb[i], to[i], 2'b00, res, v, vm);
      n_checks++;
      if (v !== 1'b1 || res !== te[i]) begin
        n_fails++;
        $display("FAIL special[%0d]: got val=%b %h expected val=1 %h", i, v, res, te[i]);
      end
    end
  endtask

  task automatic test_underflow;
    logic [31:0] ta [3] = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0001};
    logic [31:0] tb [3] = '{32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000};
    logic [1:0]  to [3] = '{2'b00, 2'b01, 2'b00};
`ifdef FMUL32_SUBNORMAL_EN
    logic [31:0] te [3] = '{32'h0040_0000, 32'h8040_0000, 32'h0000_0001};
`else
    logic [31:0] te [3] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
`endif
    logic [31:0] res;
    logic        v, vm;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], to[i], 2'b00, res, v, vm);
      n_checks++;
      if (v !== 1'b1 || res !== te[i]) begin
        n_fails++;
        $display("FAIL underflow[%0d]: got val=%b %h expected val=1 %h", i, v, res, te[i]);
      end
    end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    op1 = 32'h3F80_0000; op2 = 32'h4000_0000; opc = 2'b00; r_mode = 2'b00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (val !== 1'b1 || result !== 32'h4000_0000) begin
      n_fails++; $display("FAIL midrst_pre: got val=%b %h expected val=1 40000000", val, result);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (val !== 1'b0 || result !== 32'h0) begin
      n_fails++; $display("FAIL midrst_async: got val=%b %h expected val=0 00000000", val, result);
    end
    opc = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (val !== 1'b0) begin
      n_fails++; $display("FAIL midrst_flush: got val=%b expected 0", val);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_ops();
    test_rounding();
    test_back_to_back();
    test_overflow();
    test_specials();
    test_underflow();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fmul32.md
Name: fmul32

Overview:
- IEEE-754 binary32 floating-point multiplier with a fixed 2-cycle pipeline.
- A 2-bit opcode selects the sign treatment of the product, or a no-op.
- A 2-bit rounding-mode input selects one of four IEEE rounding directions.
- Used as the FP multiply execution unit; the software reference model is a C single-precision multiply.

Parameters:
- CANON_NAN, 32'h7FC0_0000, quiet NaN returned for every NaN result.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- op1  input  32  operand A, binary32
- op2  input  32  operand B, binary32
- opc  input  2  00 MUL (a*b); 01 NMUL -(a*b); 10 AMUL |a*b|; 11 NOP
- r_mode  input  2  00 RNE; 01 RTZ; 10 RUP (toward +inf); 11 RDN (toward -inf)
- result  output  32  binary32 product
- val  output  1  result valid

Behaviour:
- Reset (async, rst=1): all pipeline registers cleared; result=0, val=0. Asserting rst mid-operation discards in-flight ops. The first op is sampled on the first rising edge after rst deasserts.
- Pipeline, one op accepted per cycle:
  - Inputs sampled at edge N.
  - Stage 1 (edge N+1): unpack, classify, 24x24 mantissa product, exponent sum e1+e2-127, sign XOR.
  - Stage 2 (edge N+2): normalize, round, special-case mux, opc sign fix. result/val are registered outputs valid after edge N+2.
- val: 1 two cycles after an op with opc!=11. For NOP, val=0 and result holds its previous value.
- Product: implicit 1 for normal operands. Product is 48 bits; if bit47 is set, shift right 1 and increment the exponent.
- Rounding uses guard, round and sticky (OR of remaining bits):
  - RNE rounds half to even.
  - RTZ truncates.
  - RUP increments if inexact and positive.
  - RDN increments if inexact and negative.
  - Mantissa carry-out on rounding increments the exponent.
- Rounding direction uses the final sign after opc (NMUL/AMUL), i.e. the operation is fused sign-modify-then-round.
- Overflow (biased exp >= 255 after rounding):
  - RNE: ±inf.
  - RTZ: ±7F7FFFFF.
  - RUP: +inf, or -7F7FFFFF (FF7FFFFF) for negative results.
  - RDN: -inf, or +7F7FFFFF for positive results.
- Special operands:
  - Any NaN operand gives CANON_NAN (sign not modified by opc).
  - inf*0 gives CANON_NAN.
  - inf*finite-nonzero gives ±inf.
  - 0*finite gives ±0.
- Sign rules: sign = s1^s2, then NMUL inverts it and AMUL clears it.
- Underflow/subnormals: governed by the optional feature below.
- No exception flags are exported.

Optional Feature:
- Macro: FMUL32_SUBNORMAL_EN.
- Defined:
  - Subnormal inputs use implicit 0 with exponent 1, and are pre-normalized via leading-zero count.
  - Results below 2^-126 are denormalized with right shift and sticky, then rounded per r_mode. They may round up to the minimum normal.
- Undefined (flush-to-zero):
  - Subnormal inputs are treated as ±0.
  - Any result with biased exponent <= 0 before rounding becomes ±0 with the final sign.

Decomposition:
- Package fmul32_pkg holds:
  - Typedef enums opc_e (OPC_MUL, OPC_NMUL, OPC_AMUL, OPC_NOP) and rmode_e (RM_RNE, RM_RTZ, RM_RUP, RM_RDN).
  - A packed struct fp32_t {sign, exp[7:0], man[22:0]}.
  - Constants BIAS=127, EXP_MAX=255, POS_INF=32'h7F80_0000, MAX_FIN=32'h7F7F_FFFF.
- One sub-module: fmul32_round, a combinational normalize/round/overflow block taking {sign, exp, 48-bit product, r_mode}.

Test Plan:
- Reset, then opc=00, r_mode=00: 3F800000 x 40000000 gives 40000000; 3FC00000 x 40000000 gives 40400000. Both with val=1 exactly 2 cycles after sampling; val=0 during reset.
- Sign ops, op1=3FC00000, op2=40000000: opc=01 gives C0400000; opc=10 with op1=BFC00000 gives 40400000; opc=11 gives val=0 with result unchanged.
- Rounding, 3F800001 x 3F800001: RNE gives 3F800002, RTZ gives 3F800002, RUP gives 3F800003, RDN gives 3F800002. Back-to-back issue each cycle must yield one result per cycle.
- Overflow, 7F7FFFFF x 40000000: RNE gives 7F800000, RTZ gives 7F7FFFFF. With op1=FF7FFFFF: RUP gives FF7FFFFF, RDN gives FF800000.
- Specials: 7F800000 x 00000000 gives 7FC00000; 7FC00001 x 3F800000 gives 7FC00000; FF800000 x 40000000 gives FF800000; 80000000 x 3F800000 gives 80000000.
- Underflow, 00800000 x 3F000000:
  - With FMUL32_SUBNORMAL_EN: 00400000.
  - Without it: 00000000.
  - Assert rst mid-stream: val drops immediately.
